// File: rtl/address_window_pkg.sv
// rtl/address_window_pkg.sv - shared descriptor type and constants for the address window translator
package address_window_pkg;

    // Descriptors are held at a fixed maximum width so one struct serves every ADDR_WIDTH up to 32.
    localparam int DESC_ADDR_MAX    = 32;
    localparam int MISS_COUNT_WIDTH = 16;

    typedef struct packed {
        logic [DESC_ADDR_MAX-1:0] base;
        logic [DESC_ADDR_MAX:0]   count;
    } window_desc_t;

endpackage

// File: rtl/address_window_compare.sv
// rtl/address_window_compare.sv - match test of one raw address against one window descriptor
module address_window_compare
    import address_window_pkg::*;
(
    input  window_desc_t             i_desc,
    input  logic [DESC_ADDR_MAX-1:0] i_raw,
    output logic                     o_match
);

    logic [DESC_ADDR_MAX:0] w_offset;

    // One extra bit keeps the offset exact, so windows clip at the top of the address space.
    assign w_offset = {1'b0, i_raw} - {1'b0, i_desc.base};
    assign o_match  = (i_desc.count != '0) && (i_raw >= i_desc.base) && (w_offset < i_desc.count);

endmodule

// File: rtl/address_window_translator.sv
// rtl/address_window_translator.sv - 2-stage programmable address window lookup; option ADDRESS_WINDOW_TRANSLATOR_MISS_COUNT_EN adds miss_count
module address_window_translator
    import address_window_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int RANGE_COUNT = 4,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cfg_wren,
    input  logic [INDEX_WIDTH-1:0] cfg_index,
    input  logic [ADDR_WIDTH-1:0]  cfg_base,
    input  logic [ADDR_WIDTH:0]    cfg_count,
    input  logic                   in_valid,
    input  logic [ADDR_WIDTH-1:0]  raw_address,
    output logic                   out_valid,
    output logic                   out_hit,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic [ADDR_WIDTH-1:0]  translated_address
`ifdef ADDRESS_WINDOW_TRANSLATOR_MISS_COUNT_EN
    ,
    output logic [MISS_COUNT_WIDTH-1:0] miss_count
`endif
);

    window_desc_t             r_desc [RANGE_COUNT];
    logic [RANGE_COUNT-1:0]   w_match;
    logic [DESC_ADDR_MAX-1:0] w_raw_ext;
    logic [ADDR_WIDTH-1:0]    w_sel_base;

    logic                     r_s1_valid;
    logic [RANGE_COUNT-1:0]   r_s1_match;
    logic [ADDR_WIDTH-1:0]    r_s1_raw;
    logic [ADDR_WIDTH-1:0]    r_s1_base;

    logic                     w_hit;
    logic [INDEX_WIDTH-1:0]   w_index;

    logic                     r_out_valid;
    logic                     r_out_hit;
    logic [INDEX_WIDTH-1:0]   r_out_index;
    logic [ADDR_WIDTH-1:0]    r_out_trans;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RANGE_COUNT; i++) begin
                r_desc[i] <= '0;
            end
        end else if (cfg_wren) begin
            for (int i = 0; i < RANGE_COUNT; i++) begin
                if (cfg_index == INDEX_WIDTH'(i)) begin
                    r_desc[i].base  <= DESC_ADDR_MAX'(cfg_base);
                    r_desc[i].count <= (DESC_ADDR_MAX+1)'(cfg_count);
                end
            end
        end
    end

    assign w_raw_ext = DESC_ADDR_MAX'(raw_address);

    for (genvar g = 0; g < RANGE_COUNT; g++) begin : g_cmp
        address_window_compare u_cmp (
            .i_desc  (r_desc[g]),
            .i_raw   (w_raw_ext),
            .o_match (w_match[g])
        );
    end

    // The winner's base is captured alongside the match vector so a descriptor rewrite
    // in the following cycle cannot corrupt a lookup already in flight.
    always_comb begin
        w_sel_base = '0;
        for (int i = RANGE_COUNT - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_sel_base = r_desc[i].base[ADDR_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_match <= '0;
            r_s1_raw   <= '0;
            r_s1_base  <= '0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_match <= in_valid ? w_match : '0;
            r_s1_raw   <= in_valid ? raw_address : '0;
            r_s1_base  <= in_valid ? w_sel_base : '0;
        end
    end

    always_comb begin
        w_hit   = 1'b0;
        w_index = '0;
        for (int i = RANGE_COUNT - 1; i >= 0; i--) begin
            if (r_s1_match[i]) begin
                w_hit   = 1'b1;
                w_index = INDEX_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_hit   <= 1'b0;
            r_out_index <= '0;
            r_out_trans <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            r_out_hit   <= r_s1_valid && w_hit;
            r_out_index <= (r_s1_valid && w_hit) ? w_index : '0;
            r_out_trans <= (r_s1_valid && w_hit) ? (r_s1_raw - r_s1_base) : '0;
        end
    end

    assign out_valid          = r_out_valid;
    assign out_hit            = r_out_hit;
    assign out_index          = r_out_index;
    assign translated_address = r_out_trans;

`ifdef ADDRESS_WINDOW_TRANSLATOR_MISS_COUNT_EN
    logic [MISS_COUNT_WIDTH-1:0] r_miss_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_miss_count <= '0;
        end else if (r_out_valid && !r_out_hit && (r_miss_count != '1)) begin
            r_miss_count <= r_miss_count + 1'b1;
        end
    end

    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_address_window_translator.sv
// tb/tb_address_window_translator.sv - directed plus random check of address_window_translator against a window model
module tb_address_window_translator;

    localparam int AW = 12;
    localparam int RC = 4;
    localparam int IW = 2;

    typedef struct {
        bit          v;
        bit          h;
        logic [1:0]  i;
        logic [11:0] t;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          cfg_wren;
    logic [IW-1:0] cfg_index;
    logic [AW-1:0] cfg_base;
    logic [AW:0]   cfg_count;
    logic          in_valid;
    logic [AW-1:0] raw_address;
    logic          out_valid;
    logic          out_hit;
    logic [IW-1:0] out_index;
    logic [AW-1:0] translated_address;
`ifdef ADDRESS_WINDOW_TRANSLATOR_MISS_COUNT_EN
    logic [15:0]   miss_count;
`endif

    address_window_translator #(
        .ADDR_WIDTH  (AW),
        .RANGE_COUNT (RC),
        .INDEX_WIDTH (IW)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .cfg_wren           (cfg_wren),
        .cfg_index          (cfg_index),
        .cfg_base           (cfg_base),
        .cfg_count          (cfg_count),
        .in_valid           (in_valid),
        .raw_address        (raw_address),
        .out_valid          (out_valid),
        .out_hit            (out_hit),
        .out_index          (out_index),
        .translated_address (translated_address)
`ifdef ADDRESS_WINDOW_TRANSLATOR_MISS_COUNT_EN
        ,
        .miss_count         (miss_count)
`endif
    );

    always #5 clock = ~clock;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_base  [RC];
    int   m_count [RC];
    exp_t p1;
    exp_t zero_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_out(input exp_t x);
        check("out_valid", 32'(out_valid), 32'(x.v));
        check("out_hit", 32'(out_hit), 32'(x.h));
        check("out_index", 32'(out_index), 32'(x.i));
        check("translated_address", 32'(translated_address), 32'(x.t));
    endtask

    // First enabled window (lowest index) containing the address decides the result.
    function automatic exp_t model(input bit v, input int raw);
        exp_t e;
        e = '{v: 1'b0, h: 1'b0, i: 2'd0, t: 12'd0};
        if (!v) return e;
        e.v = 1'b1;
        for (int i = 0; i < RC; i++) begin
            if (m_count[i] != 0 && raw >= m_base[i] && (raw - m_base[i]) < m_count[i]) begin
                e.h = 1'b1;
                e.i = i[1:0];
                e.t = 12'(raw - m_base[i]);
                return e;
            end
        end
        return e;
    endfunction

    task automatic step(input bit lv, input int la, input bit cw = 1'b0,
                        input int ci = 0, input int cb = 0, input int cc = 0);
        exp_t e;
        in_valid    = lv;
        raw_address = AW'(la);
        cfg_wren    = cw;
        cfg_index   = IW'(ci);
        cfg_base    = AW'(cb);
        cfg_count   = (AW+1)'(cc);
        e = model(lv, la);
        if (cw) begin
            m_base[ci]  = cb;
            m_count[ci] = cc;
        end
        @(posedge clock);
        @(negedge clock);
        compare_out(p1);
        p1 = e;
    endtask

    task automatic clear_model();
        for (int i = 0; i < RC; i++) begin
            m_base[i]  = 0;
            m_count[i] = 0;
        end
    endtask

    initial begin
        zero_e = '{v: 1'b0, h: 1'b0, i: 2'd0, t: 12'd0};
        p1     = zero_e;
        clear_model();
        reset       = 1'b1;
        cfg_wren    = 1'b0;
        cfg_index   = '0;
        cfg_base    = '0;
        cfg_count   = '0;
        in_valid    = 1'b0;
        raw_address = '0;
        repeat (2) @(negedge clock);
        compare_out(zero_e);
        reset = 1'b0;

        // All windows disabled: plain miss.
        step(1, 12'h000);
        step(0, 0);
        step(0, 0);

        // Single window edges, back to back.
        step(0, 0, 1, 0, 12'h100, 13'h020);
        step(1, 12'h0FF);
        step(1, 12'h100);
        step(1, 12'h11F);
        step(1, 12'h120);

        // Overlap resolved by lowest index.
        step(0, 0, 1, 1, 12'h110, 13'h040);
        step(1, 12'h115);
        step(1, 12'h125);

        // Window reaching past the top of the address space clips, no wrap.
        step(0, 0, 1, 2, 12'hFF0, 13'h100);
        step(1, 12'hFFF);
        step(1, 12'h005);

        // Lookup in the write cycle sees old descriptors; next cycle sees new.
        step(1, 12'h200, 1, 3, 12'h200, 13'h001);
        step(1, 12'h200);
        step(0, 0);
        step(0, 0);

        // Random lookups with occasional descriptor rewrites.
        for (int n = 0; n < 300; n++) begin
            bit lv;
            bit cw;
            int ci;
            int cb;
            int cc;
            int la;
            int sel;
            lv  = ($urandom_range(0, 3) != 0);
            cw  = ($urandom_range(0, 7) == 0);
            ci  = int'($urandom_range(0, RC - 1));
            cb  = int'($urandom_range(0, 4095));
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       cc = 0;
                1:       cc = int'($urandom_range(1, 16'h040));
                2:       cc = int'($urandom_range(1, 16'h200));
                default: cc = int'($urandom_range(0, 16'h1000));
            endcase
            if ($urandom_range(0, 1) == 0) begin
                la = m_base[$urandom_range(0, RC - 1)] + int'($urandom_range(0, 16'h60)) - 16'h10;
                if (la < 0) la = 0;
                if (la > 4095) la = 4095;
            end else begin
                la = int'($urandom_range(0, 4095));
            end
            step(lv, la, cw, ci, cb, cc);
        end
        step(0, 0);
        step(0, 0);

        // Reset with two lookups in flight: nothing emerges, descriptors cleared.
        step(0, 0, 1, 0, 12'h100, 13'h020);
        step(1, 12'h100);
        in_valid    = 1'b1;
        raw_address = 12'h105;
        #2 reset = 1'b1;
        #1 compare_out(zero_e);
        @(posedge clock);
        @(negedge clock);
        compare_out(zero_e);
        reset    = 1'b0;
        in_valid = 1'b0;
        p1       = zero_e;
        clear_model();
        step(0, 0);
        step(0, 0);
        step(1, 12'h100);
        step(1, 12'h115);
        step(0, 0);
        step(0, 0);

`ifdef ADDRESS_WINDOW_TRANSLATOR_MISS_COUNT_EN
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        p1    = zero_e;
        clear_model();
        check("miss_count_reset", 32'(miss_count), 32'd0);
        step(1, 12'h001);
        step(1, 12'h002);
        step(1, 12'h003);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        check("miss_count_three", 32'(miss_count), 32'd3);
        reset = 1'b1;
        #1 check("miss_count_cleared", 32'(miss_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
